// File: rtl/colorshield_scan_ctrl_if.sv
// colorshield_scan_ctrl_if: frame-buffer read port plus the
// transmit_unit run/latch handshake used by the row scanner.
interface colorshield_scan_ctrl_if #(
   parameter int AW = 8
);
   logic [AW-1:0] fb_addr;
   logic [7:0]    fb_data;
   logic [7:0]    tx_data;
   logic          tx_run;
   logic          tx_done_n;

   modport master (
      output fb_addr,
      input  fb_data,
      output tx_data,
      output tx_run,
      input  tx_done_n
   );

   modport slave (
      input  fb_addr,
      output fb_data,
      input  tx_data,
      input  tx_run,
      output tx_done_n
   );
endinterface

// File: rtl/colorshield_scan_ctrl.sv
// colorshield_scan_ctrl: row-scan scheduler for the 8x8 RGB colorshield.
// Define SCAN_BLANK_EN to drive rows only during the dwell window.
module colorshield_scan_ctrl #(
   parameter int ROWS          = 8,
   parameter int BYTES_PER_ROW = 24,
   parameter int DWELL         = 1024,
   parameter int AW            = $clog2(ROWS*BYTES_PER_ROW)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   colorshield_scan_ctrl_if.master bus,
   output logic                    sb_lat,
   output logic [ROWS-1:0]         row_en,
   output logic                    frame_done,
   output logic                    busy
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BW = (BYTES_PER_ROW > 1) ?
                       $clog2(BYTES_PER_ROW) : 1;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS-1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES_PER_ROW-1);
   localparam logic [CW-1:0] CNT_LOAD  = CW'(DWELL-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SEND,
      S_WAIT,
      S_LATCH,
      S_DWELL
   } state_t;

   state_t          state_q, state_n;
   logic [RW-1:0]   row_q, row_n;
   logic [BW-1:0]   byte_q, byte_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic            wrap;
   logic [ROWS-1:0] row_hot;

   assign row_hot = ROWS'(1) << row_q;

   always_comb begin
      state_n = state_q;
      row_n   = row_q;
      byte_n  = byte_q;
      cnt_n   = cnt_q;
      wrap    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            byte_n = '0;
            if (enable) state_n = S_FETCH;
         end
         S_FETCH: state_n = S_LOAD;
         S_LOAD:  state_n = S_SEND;
         S_SEND:  state_n = S_WAIT;
         S_WAIT: begin
            if (!bus.tx_done_n) begin
               if (byte_q != BYTE_LAST) begin
                  byte_n  = byte_q + 1'b1;
                  state_n = S_FETCH;
               end else begin
                  state_n = S_LATCH;
               end
            end
         end
         S_LATCH: begin
            cnt_n   = CNT_LOAD;
            state_n = S_DWELL;
         end
         S_DWELL: begin
            if (cnt_q == '0) begin
               byte_n  = '0;
               wrap    = (row_q == ROW_LAST);
               row_n   = wrap ? '0 : row_q + 1'b1;
               state_n = enable ? S_FETCH : S_IDLE;
            end else begin
               cnt_n = cnt_q - 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         byte_q      <= '0;
         cnt_q       <= '0;
         bus.fb_addr <= '0;
         bus.tx_data <= '0;
         bus.tx_run  <= 1'b0;
         sb_lat      <= 1'b0;
         row_en      <= '0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_n;
         row_q       <= row_n;
         byte_q      <= byte_n;
         cnt_q       <= cnt_n;
         // address tracks the counters so FETCH sees it on entry
         bus.fb_addr <= AW'(int'(row_n) * BYTES_PER_ROW
                        + int'(byte_n));
         if (state_q == S_LOAD) bus.tx_data <= bus.fb_data;
         bus.tx_run  <= (state_n == S_SEND);
         sb_lat      <= (state_n == S_LATCH);
         frame_done  <= wrap;
         busy        <= (state_n != S_IDLE);
`ifdef SCAN_BLANK_EN
         row_en <= (state_n == S_DWELL) ? row_hot : '0;
`else
         // DM163 holds its outputs until LAT, so the row may stay lit
         if (state_n == S_IDLE)       row_en <= '0;
         else if (state_q == S_LATCH) row_en <= row_hot;
`endif
      end
   end
endmodule

// File: tb/tb_colorshield_scan_ctrl.sv
// tb_colorshield_scan_ctrl: directed table-driven bench with a
// 1-cycle RAM and a transmit_unit model answering 20 cycles after run.
module tb_colorshield_scan_ctrl;
   localparam int ROWS = 8;
   localparam int BPR  = 24;
   localparam int DW   = 4;
   localparam int AW   = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enable = 1'b0;
   logic            sb_lat;
   logic            frame_done;
   logic            busy;
   logic [ROWS-1:0] row_en;
   logic            done_q = 1'b1;
   logic            spur = 1'b0;
   logic            inj_en = 1'b0;
   logic            lat_d = 1'b0;
   int              tcnt = 0;

   colorshield_scan_ctrl_if #(.AW(AW)) bus ();

   colorshield_scan_ctrl #(
      .ROWS(ROWS),
      .BYTES_PER_ROW(BPR),
      .DWELL(DW),
      .AW(AW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .bus(bus),
      .sb_lat(sb_lat),
      .row_en(row_en),
      .frame_done(frame_done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.fb_data <= 8'(bus.fb_addr);

   always @(posedge clk) begin
      done_q <= 1'b1;
      if (!rst_n) tcnt <= 0;
      else if (bus.tx_run) tcnt <= 20;
      else if (tcnt != 0) begin
         tcnt <= tcnt - 1;
         if (tcnt == 1) done_q <= 1'b0;
      end
   end

   assign bus.tx_done_n = done_q & ~spur;

   // spurious latch pulses in SEND and in the first DWELL cycle
   always @(negedge clk) begin
      spur  = inj_en && (bus.tx_run || lat_d);
      lat_d = sb_lat;
   end

   int         runs = 0;
   int         lats = 0;
   int         frames = 0;
   int         max_addr = 0;
   int         bad_row = 0;
   logic [7:0] hist [4096];
`ifndef SCAN_BLANK_EN
   logic       seen_lat = 1'b0;
`endif

   always @(negedge clk) begin
      if (bus.tx_run) begin
         if (runs < 4096) hist[runs] = bus.tx_data;
         runs++;
      end
      if (sb_lat) lats++;
      if (frame_done) frames++;
      if (int'(bus.fb_addr) > max_addr)
         max_addr = int'(bus.fb_addr);
      if (!$onehot0(row_en)) bad_row++;
`ifdef SCAN_BLANK_EN
      if (row_en != '0 &&
          (bus.tx_run || sb_lat || !done_q || !busy))
         bad_row++;
`else
      if (seen_lat && busy && row_en == '0) bad_row++;
      if (!busy) seen_lat = 1'b0;
      else if (sb_lat) seen_lat = 1'b1;
`endif
   end

   int n_chk = 0;
   int n_pass = 0;
   int lat_runs = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h",
                    name, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_lat(input string name, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         if (sb_lat) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check({name, " timeout"}, 0, 1);
   endtask

   task automatic row_bytes(input string name,
                            input logic [7:0] first);
      int good;
      good = 0;
      check({name, " runs"}, runs - lat_runs, BPR);
      if (runs >= BPR)
         for (int b = 0; b < BPR; b++)
            if (hist[runs-BPR+b] == first + 8'(b)) good++;
      check({name, " data"}, good, BPR);
   endtask

   typedef struct {
      int         row;
      logic [7:0] first;
      logic [7:0] last;
      logic [7:0] hot;
      bit         frame;
   } vec_t;

   vec_t tbl [ROWS];

   task automatic scan_rows(input int n);
      bit   ok;
      int   good;
      int   nxt;
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v = tbl[i];
         wait_lat($sformatf("row%0d lat", v.row), ok);
         if (!ok) return;
         row_bytes($sformatf("row%0d", v.row), v.first);
         check($sformatf("row%0d last", v.row),
               hist[(runs-1) & 4095], v.last);
         lat_runs = runs;
         step(1);
         check($sformatf("row%0d lat pulse", v.row), sb_lat, 0);
         good = 0;
         for (int k = 1; k <= DW; k++) begin
            if (row_en == v.hot && busy) good++;
            step(1);
         end
         check($sformatf("row%0d dwell", v.row), good, DW);
         nxt = ((v.row + 1) % ROWS) * BPR;
         check($sformatf("row%0d next addr", v.row),
               bus.fb_addr, nxt);
         check($sformatf("row%0d frame_done", v.row),
               frame_done, v.frame);
`ifdef SCAN_BLANK_EN
         check($sformatf("row%0d blank", v.row), row_en, 0);
`else
         check($sformatf("row%0d hold", v.row), row_en, v.hot);
`endif
         step(1);
         check($sformatf("row%0d load", v.row), bus.tx_run, 0);
         step(1);
         check($sformatf("row%0d run", v.row), bus.tx_run, 1);
         check($sformatf("row%0d tx", v.row), bus.tx_data, nxt);
      end
   endtask

   initial begin
      bit ok;
      int r0;
      int f0;
      int good;
      int k;

      tbl[0] = '{0, 8'h00, 8'h17, 8'h01, 1'b0};
      tbl[1] = '{1, 8'h18, 8'h2F, 8'h02, 1'b0};
      tbl[2] = '{2, 8'h30, 8'h47, 8'h04, 1'b0};
      tbl[3] = '{3, 8'h48, 8'h5F, 8'h08, 1'b0};
      tbl[4] = '{4, 8'h60, 8'h77, 8'h10, 1'b0};
      tbl[5] = '{5, 8'h78, 8'h8F, 8'h20, 1'b0};
      tbl[6] = '{6, 8'h90, 8'hA7, 8'h40, 1'b0};
      tbl[7] = '{7, 8'hA8, 8'hBF, 8'h80, 1'b1};

      step(3);
      check("rst fb_addr", bus.fb_addr, 0);
      check("rst tx_data", bus.tx_data, 0);
      check("rst tx_run", bus.tx_run, 0);
      check("rst sb_lat", sb_lat, 0);
      check("rst row_en", row_en, 0);
      check("rst frame_done", frame_done, 0);
      check("rst busy", busy, 0);
      rst_n = 1'b1;
      step(2);
      check("idle busy", busy, 0);

      lat_runs = runs;
      enable = 1'b1;
      step(1);
      check("fetch busy", busy, 1);
      check("fetch addr", bus.fb_addr, 0);
      check("fetch run", bus.tx_run, 0);
      step(1);
      check("load run", bus.tx_run, 0);
      step(1);
      check("send run", bus.tx_run, 1);
      check("send data", bus.tx_data, 0);
      step(1);
      check("run pulse", bus.tx_run, 0);
      check("data hold", bus.tx_data, 0);

      scan_rows(ROWS);
      check("max addr", max_addr, 191);
      check("frames", frames, 1);

      inj_en = 1'b1;
      scan_rows(3);
      k = 0;
      while (runs - lat_runs < 11 && k < 1000) begin
         step(1);
         k++;
      end
      check("reach byte 10", runs - lat_runs, 11);
      enable = 1'b0;
      f0 = frames;
      wait_lat("row3 lat", ok);
      row_bytes("row3 drop", 8'h48);
      lat_runs = runs;
      r0 = runs;
      good = 0;
      for (int j = 1; j <= DW; j++) begin
         step(1);
         if (row_en == 8'h08 && busy) good++;
      end
      check("drop dwell", good, DW);
      step(1);
      check("drop busy", busy, 0);
      check("drop row_en", row_en, 0);
      step(50);
      check("drop no run", runs, r0);
      check("drop idle", busy, 0);
      check("drop frames", frames, f0);
      inj_en = 1'b0;

      enable = 1'b1;
      step(1);
      check("resume addr", bus.fb_addr, 96);
      check("resume busy", busy, 1);
      k = 0;
      while (!bus.tx_run && k < 10) begin
         step(1);
         k++;
      end
      check("resume run", bus.tx_run, 1);
      check("resume data", bus.tx_data, 96);
      step(5);
      rst_n = 1'b0;
      step(1);
      check("mid rst outs",
            {bus.fb_addr, bus.tx_data, bus.tx_run, sb_lat,
             row_en, frame_done, busy}, 0);
      rst_n = 1'b1;
      lat_runs = runs;
      step(1);
      check("restart addr", bus.fb_addr, 0);
      check("restart busy", busy, 1);
      step(2);
      check("restart run", bus.tx_run, 1);
      check("restart data", bus.tx_data, 0);
      scan_rows(1);

      check("row drive", bad_row, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/colorshield_scan_ctrl.md
# colorshield_scan_ctrl

Row-scan scheduler for the 8x8 RGB colorshield: walks a byte-wide frame buffer row by row, feeds each byte to `transmit_unit` through its `run`/`latch` handshake, pulses the DM163 latch after each row, and drives the one-hot row enable for a programmable dwell time. It sits between the frame buffer and `transmit_unit` and is the only block that issues `run`.

## Interface

Reset is synchronous and active-low; `clk` is the only clock.

Parameters:
- `ROWS`, 8: rows per frame.
- `BYTES_PER_ROW`, 24: channel bytes per row (8 pixels x RGB).
- `DWELL`, 1024: clk cycles each row stays enabled after its latch, 1..2^16.
- `AW`, `$clog2(ROWS*BYTES_PER_ROW)`: frame-buffer address width.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: level; scanning runs while high.
- `fb_addr` out AW: frame-buffer read address, registered.
- `fb_data` in 8: read data, valid exactly 1 cycle after `fb_addr` changes.
- `tx_data` out 8: byte to `transmit_unit.data`, registered.
- `tx_run` out 1: one-cycle start pulse to `transmit_unit.run`.
- `tx_done_n` in 1: `transmit_unit.latch`; a one-cycle low pulse means the byte is fully shifted.
- `sb_lat` out 1: one-cycle high pulse to DM163 LAT after the last byte of a row.
- `row_en` out ROWS: one-hot row drive; all zero when dark.
- `frame_done` out 1: one-cycle pulse at the end of the last row's dwell.
- `busy` out 1: high in every state except IDLE.

## Operation

Counters:
- `row` counts 0..ROWS-1.
- `byte` counts 0..BYTES_PER_ROW-1.
- `fb_addr = row*BYTES_PER_ROW + byte`, bytes in ascending order within a row.

States and transitions:
- IDLE: go to FETCH when `enable`=1. Clears `byte`.
- FETCH: drive `fb_addr`, then go to LOAD.
- LOAD: `fb_data` is valid. Register `tx_data <= fb_data` and `tx_run <= 1`, then go to SEND.
- SEND: `tx_run` and `tx_data` are visible this cycle. Next cycle `tx_run` = 0 and the FSM goes to WAIT. `tx_data` holds its value.
- WAIT: wait for `tx_done_n`=0. If `byte` < BYTES_PER_ROW-1, increment `byte` and go to FETCH. Otherwise go to LATCH.
- LATCH: `sb_lat`=1 for one cycle. Load the dwell counter with DWELL-1, then go to DWELL.
- DWELL: decrement each cycle; at 0 clear `byte` and advance `row`.
  - `row` wraps ROWS-1 -> 0. On the wrap, pulse `frame_done` in that same cycle.
  - Next state is FETCH if `enable`=1, else IDLE.

Row drive without `SCAN_BLANK_EN`:
- `row_en` updates to one-hot(`row`) on the cycle after LATCH.
- It holds that value through the next row's shifting, which is correct because DM163 outputs hold their data until LAT.
- It clears only in IDLE.

Boundary rules:
- `enable` deasserted mid-row: the current row completes through DWELL, then the FSM goes to IDLE. No partial rows are ever latched.
- `tx_done_n` low outside WAIT is ignored.
- `tx_done_n` is never sampled in the cycle SEND is entered.
- Reset at any point: next edge gives state IDLE, `row`=0, `byte`=0, all counters 0.

Reset value of every output is 0: `fb_addr`, `tx_data`, `tx_run`, `sb_lat`, `row_en`, `frame_done`, `busy`.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- Per byte: 3 controller cycles (FETCH, LOAD, SEND) plus the `transmit_unit` shift time, up to and including the `tx_done_n` cycle. The next FETCH starts the cycle after `tx_done_n` is observed.
- Per row: BYTES_PER_ROW byte cycles + 1 (LATCH) + DWELL.
- `sb_lat` is asserted the cycle after the final `tx_done_n` of the row.
- `tx_run` is never reasserted before `tx_done_n` has been seen, so `transmit_unit` is always in INIT when it is run.

## Configuration

- `SCAN_BLANK_EN` defined:
  - `row_en` is one-hot(`row`) only while in DWELL and zero in every other state, blanking ghosting during shift and latch.
  - `row_en` asserts the cycle after LATCH and drops the cycle after DWELL ends.
- Undefined: the row-drive rule in Operation applies, giving no dark gap between rows.

## Test plan

All scenarios use a behavioural `transmit_unit` model that pulses `tx_done_n` 20 cycles after `tx_run`, and a 1-cycle-latency RAM.

- Reset, then `enable`=1 with the RAM holding `fb[a]=a`:
  - `tx_data` sequence is 0x00..0x17 for row 0.
  - `sb_lat` pulses once, then `row_en`=8'h01 for DWELL cycles.
- Full frame with DWELL=4:
  - `fb_addr` reaches 191.
  - `frame_done` pulses once, then `fb_addr` wraps to 0 and `row_en` cycles 01,02,...,80.
- `enable` dropped during row 3 byte 10:
  - Row 3 completes: 24 `tx_run` pulses, one `sb_lat`, full dwell.
  - Then `busy`=0 and `row_en`=0.
- `rst_n`=0 for one cycle mid-WAIT:
  - All outputs are 0 next cycle.
  - With `enable` still high, the restart begins at `fb_addr`=0.
- Spurious `tx_done_n` pulse during DWELL and in SEND: no byte is skipped and the count per row stays 24.
- Build with `SCAN_BLANK_EN`: `row_en`=0 during every FETCH/LOAD/SEND/WAIT/LATCH cycle; without it, `row_en` never reads 0 between rows.
